shot_hit_responder: RTL
=======================

Name: shot_hit_responder

Overview:
- Target-side counterpart of the shot mover. It watches the live shot's pixel drawing requests against walls and monsters, and reports a one-cycle fireCollision back to the shot mover.
- Also reports which monster was hit, with a score increment.
- Gates the player's fire key through a frame-counted reload, so a new shot can only launch after the previous one has been resolved.
- Sits between the drawing-request mux, the shot mover and the score block.

Parameters:
- NUM_MONSTERS, 4, number of monster drawing-request inputs (1..8).
- RELOAD_FRAMES, 30, frames after a hit before fire is re-enabled (0..255; 0 = no reload).
- MONSTER_SCORE, 8'd250, value placed on score_add for a monster kill.
- BORDER_LEFT, 11'd32, lowest legal shot X.
- BORDER_RIGHT, 11'd600, highest legal shot X.
- BORDER_TOP, 11'd160, lowest legal shot Y.
- BORDER_BOTTOM, 11'd460, highest legal shot Y.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- fire_key  in  1  raw fire request from the keyboard block.
- shot_alive  in  1  alive flag from the shot mover.
- shotDrawingRequest  in  1  shot pixel active at the current VGA pixel.
- wallDrawingRequest  in  1  wall/dirt-edge pixel active.
- monsterDrawingRequest  in  NUM_MONSTERS  per-monster pixel active.
- shotTopLeftX  in  11  shot position X.
- shotTopLeftY  in  11  shot position Y.
- fire_pressed  out  1  gated fire, to the shot mover.
- fireCollision  out  1  one-cycle kill pulse, to the shot mover.
- monster_hit  out  NUM_MONSTERS  one-hot kill pulse, to the monsters.
- score_add  out  8  score increment, valid while fireCollision=1.
- reload_active  out  1  high while reloading.

Behaviour:
- Reset (asynchronous, resetN=0):
  - state=READY; all flags and the counter clear.
  - fire_pressed=0, fireCollision=0, monster_hit=0, score_add=0, reload_active=0.
  - A reset mid-flight or mid-reload abandons everything; no pulse is emitted.
- Pixel accumulation (any state, only while shot_alive=1), per cycle:
  - wall_flag |= shotDrawingRequest & wallDrawingRequest.
  - mon_flag[i] |= shotDrawingRequest & monsterDrawingRequest[i].
  - Flags clear on the cycle of startOfFrame, after evaluation.
  - A pixel coincident with startOfFrame belongs to the ending frame: evaluation uses flag OR the current-cycle term.
- States and transitions:
  - READY: fire_pressed <= fire_key (registered, 1-cycle latency). Go to FLYING when shot_alive=1.
  - FLYING: fire_pressed=0.
    - On startOfFrame with any flag set, go to HIT.
    - If shot_alive falls with no hit pending, go to READY.
  - HIT: lasts exactly 1 cycle; fireCollision=1.
    - If any mon_flag is set, monster_hit is one-hot at the lowest set index and score_add=MONSTER_SCORE; otherwise monster_hit=0 and score_add=0.
    - A simultaneous wall and monster hit reports the monster.
    - Next state is RELOAD, or READY if RELOAD_FRAMES==0.
  - RELOAD: reload_active=1, fire_pressed=0.
    - The 8-bit counter starts at 0 and increments on each startOfFrame.
    - When the counter reaches RELOAD_FRAMES-1 on a startOfFrame, go to READY and clear the counter.
    - fire_key is ignored and not buffered; it must still be held once READY.
- In every state other than HIT: fireCollision, monster_hit and score_add are 0.
- At most one HIT per frame.
- A shot_alive glitch in RELOAD is ignored.

Optional Feature:
- Macro: SHOT_BORDER_KILL_EN.
- With the macro: in FLYING, at startOfFrame, the shot is out of bounds if shotTopLeftX < BORDER_LEFT, shotTopLeftX > BORDER_RIGHT, shotTopLeftY < BORDER_TOP, or shotTopLeftY > BORDER_BOTTOM. Out of bounds counts as a hit with no monster: go to HIT, score_add=0.
  - Comparisons are unsigned, so an 11-bit position that wrapped below 0 reads as large and triggers BORDER_RIGHT/BOTTOM.
- Without the macro: the border ports are unused, and only pixel collisions end a shot.

Decomposition:
- Package shot_pkg holds:
  - typedef enum logic [1:0] {READY, FLYING, HIT, RELOAD} shot_state_t;
  - FIXED_POINT_MULTIPLIER=64;
  - default border constants.
- One natural sub-module: shot_frame_counter, an 8-bit startOfFrame counter with clear and terminal-count compare, used for RELOAD.

Test Plan:
- Reset, fire_key=1, shot_alive=0: fire_pressed=1 one cycle after fire_key, and stays 1 while fire_key is held. Raise shot_alive, and fire_pressed drops to 0 the cycle after entering FLYING.
- FLYING, one cycle with shotDrawingRequest=1 and monsterDrawingRequest=4'b0110, then startOfFrame: a single cycle of fireCollision=1, monster_hit=4'b0010, score_add=250.
- FLYING, wall pixel and monster[3] pixel in the same frame: monster_hit=4'b1000, score_add=250, exactly one pulse.
- After a hit with RELOAD_FRAMES=3, fire_key held: reload_active=1 for 3 startOfFrames, fire_pressed=0 throughout, then fire_pressed=1 the cycle after READY is entered.
- Wall pixel coincident with the startOfFrame cycle: fireCollision on the next cycle; no hit carried into the following frame.
- SHOT_BORDER_KILL_EN defined, shotTopLeftX=11'd2047 at startOfFrame: fireCollision=1, score_add=0. Undefined: no pulse.

Source files
------------

// File: rtl/shot_pkg.sv
// -----------------------------------------------------------------------------
// shot_pkg
// Shared types and constants for the shot hit responder and its helpers.
//   shot_state_t           : responder FSM states
//   FIXED_POINT_MULTIPLIER : position scaling shared with the shot mover
//   DEF_*                  : default playfield borders and monster score
//   lowest_set_onehot      : isolate the lowest set bit of an 8-bit vector
// -----------------------------------------------------------------------------
package shot_pkg;

    typedef enum logic [1:0] {
        READY  = 2'd0,
        FLYING = 2'd1,
        HIT    = 2'd2,
        RELOAD = 2'd3
    } shot_state_t;

    localparam int FIXED_POINT_MULTIPLIER = 64;

    localparam logic [10:0] DEF_BORDER_LEFT   = 11'd32;
    localparam logic [10:0] DEF_BORDER_RIGHT  = 11'd600;
    localparam logic [10:0] DEF_BORDER_TOP    = 11'd160;
    localparam logic [10:0] DEF_BORDER_BOTTOM = 11'd460;
    localparam logic [7:0]  DEF_MONSTER_SCORE = 8'd250;

    // Two's-complement trick: v & -v keeps only the lowest set bit.
    function automatic logic [7:0] lowest_set_onehot(input logic [7:0] v);
        lowest_set_onehot = v & (~v + 8'd1);
    endfunction

endpackage

// File: rtl/shot_frame_counter.sv
// -----------------------------------------------------------------------------
// shot_frame_counter
// 8-bit frame counter used to time the reload period. Counts inc_i pulses
// (one per frame) from zero; when a pulse arrives while the count equals
// terminal_i, tc_o fires and the counter wraps back to zero on the same edge.
// Ports:
//   clk, resetN  : clock, asynchronous active-low reset
//   clear_i      : hold the counter at zero
//   inc_i        : frame pulse, advances the count
//   terminal_i   : last count value before tc_o
//   tc_o         : terminal-count strobe (combinational, qualified by inc_i)
// -----------------------------------------------------------------------------
module shot_frame_counter
    import shot_pkg::*;
(
    input  logic       clk,
    input  logic       resetN,
    input  logic       clear_i,
    input  logic       inc_i,
    input  logic [7:0] terminal_i,
    output logic       tc_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    assign tc_o = inc_i && (count_q == terminal_i);

    // Next count: clear wins, terminal count wraps to zero, otherwise advance.
    always_comb begin
        count_d = count_q;
        if (clear_i || tc_o) begin
            count_d = 8'd0;
        end else if (inc_i) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/shot_hit_responder.sv
// -----------------------------------------------------------------------------
// shot_hit_responder
// Target-side partner of the shot mover. Accumulates shot/wall and
// shot/monster pixel coincidences over a frame, and at startOfFrame turns a
// pending coincidence into a one-cycle fireCollision with the lowest-index
// monster reported one-hot and a score increment. After a hit the fire key is
// blocked for RELOAD_FRAMES frames.
//
// Optional build macro SHOT_BORDER_KILL_EN: a shot outside the BORDER_*
// window at startOfFrame is treated as a hit with no monster.
//
// Ports:
//   clk, resetN            : clock, asynchronous active-low reset
//   startOfFrame           : one-cycle pulse per frame
//   fire_key               : raw fire request
//   shot_alive             : shot mover's alive flag
//   shotDrawingRequest     : shot pixel active
//   wallDrawingRequest     : wall pixel active
//   monsterDrawingRequest  : per-monster pixel active
//   shotTopLeftX/Y         : shot position
//   fire_pressed           : gated fire to the shot mover
//   fireCollision          : one-cycle kill pulse
//   monster_hit            : one-hot monster kill pulse
//   score_add              : score increment, valid with fireCollision
//   reload_active          : high while reloading
// -----------------------------------------------------------------------------
module shot_hit_responder
    import shot_pkg::*;
#(
    parameter int          NUM_MONSTERS  = 4,
    parameter int          RELOAD_FRAMES = 30,
    parameter logic [7:0]  MONSTER_SCORE = DEF_MONSTER_SCORE,
    parameter logic [10:0] BORDER_LEFT   = DEF_BORDER_LEFT,
    parameter logic [10:0] BORDER_RIGHT  = DEF_BORDER_RIGHT,
    parameter logic [10:0] BORDER_TOP    = DEF_BORDER_TOP,
    parameter logic [10:0] BORDER_BOTTOM = DEF_BORDER_BOTTOM
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    fire_key,
    input  logic                    shot_alive,
    input  logic                    shotDrawingRequest,
    input  logic                    wallDrawingRequest,
    input  logic [NUM_MONSTERS-1:0] monsterDrawingRequest,
    input  logic [10:0]             shotTopLeftX,
    input  logic [10:0]             shotTopLeftY,
    output logic                    fire_pressed,
    output logic                    fireCollision,
    output logic [NUM_MONSTERS-1:0] monster_hit,
    output logic [7:0]              score_add,
    output logic                    reload_active
);

    localparam bit         HAS_RELOAD = (RELOAD_FRAMES != 0);
    localparam logic [7:0] RELOAD_TC  = HAS_RELOAD ? 8'(RELOAD_FRAMES - 1) : 8'd0;

    shot_state_t             state_q, state_d;
    logic                    wall_flag_q, wall_flag_d;
    logic [NUM_MONSTERS-1:0] mon_flag_q, mon_flag_d;
    logic                    fire_pressed_q, fire_pressed_d;
    logic                    fire_collision_q, fire_collision_d;
    logic [NUM_MONSTERS-1:0] monster_hit_q, monster_hit_d;
    logic [7:0]              score_add_q, score_add_d;
    logic                    reload_active_q, reload_active_d;

    logic                    wall_term_s;
    logic [NUM_MONSTERS-1:0] mon_term_s;
    logic                    wall_eval_s;
    logic [NUM_MONSTERS-1:0] mon_eval_s;
    logic [NUM_MONSTERS-1:0] mon_onehot_s;
    logic                    any_hit_s;
    logic                    oob_s;
    logic                    reload_inc_s;
    logic                    reload_clear_s;
    logic                    reload_done_s;

    // Current-cycle coincidences; nothing accumulates without a live shot.
    assign wall_term_s = shot_alive & shotDrawingRequest & wallDrawingRequest;
    assign mon_term_s  = {NUM_MONSTERS{shot_alive & shotDrawingRequest}} & monsterDrawingRequest;

    // A pixel on the startOfFrame cycle still belongs to the frame that ends.
    assign wall_eval_s  = wall_flag_q | wall_term_s;
    assign mon_eval_s   = mon_flag_q | mon_term_s;
    assign any_hit_s    = wall_eval_s | (|mon_eval_s);
    assign mon_onehot_s = NUM_MONSTERS'(lowest_set_onehot(8'(mon_eval_s)));

`ifdef SHOT_BORDER_KILL_EN
    // Unsigned compares: a position that wrapped below zero reads as large.
    assign oob_s = (shotTopLeftX < BORDER_LEFT) || (shotTopLeftX > BORDER_RIGHT) ||
                   (shotTopLeftY < BORDER_TOP)  || (shotTopLeftY > BORDER_BOTTOM);
`else
    logic unused_border_s;
    assign oob_s           = 1'b0;
    assign unused_border_s = ^{shotTopLeftX, shotTopLeftY, BORDER_LEFT, BORDER_RIGHT,
                               BORDER_TOP, BORDER_BOTTOM};
`endif

    // Reload timer only runs in RELOAD and sits at zero everywhere else.
    assign reload_inc_s   = (state_q == RELOAD) && startOfFrame;
    assign reload_clear_s = (state_q != RELOAD);

    shot_frame_counter u_reload_cnt (
        .clk        (clk),
        .resetN     (resetN),
        .clear_i    (reload_clear_s),
        .inc_i      (reload_inc_s),
        .terminal_i (RELOAD_TC),
        .tc_o       (reload_done_s)
    );

    // Hit flags: sticky within a frame, cleared once the frame is evaluated.
    always_comb begin
        wall_flag_d = wall_flag_q;
        mon_flag_d  = mon_flag_q;
        if (startOfFrame) begin
            wall_flag_d = 1'b0;
            mon_flag_d  = '0;
        end else begin
            wall_flag_d = wall_flag_q | wall_term_s;
            mon_flag_d  = mon_flag_q | mon_term_s;
        end
    end

    // FSM next state and next registered outputs; outputs default to idle.
    always_comb begin
        state_d          = state_q;
        fire_pressed_d   = 1'b0;
        fire_collision_d = 1'b0;
        monster_hit_d    = '0;
        score_add_d      = 8'd0;
        reload_active_d  = 1'b0;
        case (state_q)
            READY: begin
                fire_pressed_d = fire_key;
                if (shot_alive) begin
                    state_d = FLYING;
                end else begin
                    state_d = READY;
                end
            end
            FLYING: begin
                if (startOfFrame && (any_hit_s || oob_s)) begin
                    state_d          = HIT;
                    fire_collision_d = 1'b1;
                    // Monster outranks wall or border when both occurred.
                    if (|mon_eval_s) begin
                        monster_hit_d = mon_onehot_s;
                        score_add_d   = MONSTER_SCORE;
                    end else begin
                        monster_hit_d = '0;
                        score_add_d   = 8'd0;
                    end
                end else if (!shot_alive && !any_hit_s) begin
                    state_d = READY;
                end else begin
                    state_d = FLYING;
                end
            end
            HIT: begin
                if (HAS_RELOAD) begin
                    state_d         = RELOAD;
                    reload_active_d = 1'b1;
                end else begin
                    state_d = READY;
                end
            end
            RELOAD: begin
                if (reload_done_s) begin
                    state_d = READY;
                end else begin
                    state_d         = RELOAD;
                    reload_active_d = 1'b1;
                end
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    // State, flags and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q          <= READY;
            wall_flag_q      <= 1'b0;
            mon_flag_q       <= '0;
            fire_pressed_q   <= 1'b0;
            fire_collision_q <= 1'b0;
            monster_hit_q    <= '0;
            score_add_q      <= 8'd0;
            reload_active_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            wall_flag_q      <= wall_flag_d;
            mon_flag_q       <= mon_flag_d;
            fire_pressed_q   <= fire_pressed_d;
            fire_collision_q <= fire_collision_d;
            monster_hit_q    <= monster_hit_d;
            score_add_q      <= score_add_d;
            reload_active_q  <= reload_active_d;
        end
    end

    assign fire_pressed  = fire_pressed_q;
    assign fireCollision = fire_collision_q;
    assign monster_hit   = monster_hit_q;
    assign score_add     = score_add_q;
    assign reload_active = reload_active_q;

endmodule
